// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and access sequencer for the single-ported 16-bit data memory bank.
// Two requesters share the bank; each access is IDLE -> ACCESS -> DONE with registered strobes and ack.
module dmem_arbiter #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic              we0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic              we1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic              busy,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
    localparam int unsigned      CMP_W = ADDR_W + 1;
    localparam logic [CMP_W-1:0] DEPTH_X = CMP_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_e;

    state_e              state_q, state_d;
    logic                last_gnt_q, last_gnt_d;
    logic                port_q, port_d;
    logic                we_q, we_d;
    logic                ack0_q, ack0_d;
    logic                ack1_q, ack1_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;
    logic                busy_q, busy_d;
    logic                mem_read_q, mem_read_d;
    logic                mem_write_q, mem_write_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

    logic                gnt_port;
    logic [ADDR_W-1:0]   sel_addr;
    logic                sel_we;
    logic [DATA_W-1:0]   sel_wdata;
    logic                sel_in_range;

    // Grant selection: a lone requester wins; on a tie the port not granted last time wins.
    always_comb begin
        gnt_port     = (req0 && req1) ? ~last_gnt_q : req1;
        sel_addr     = gnt_port ? addr1  : addr0;
        sel_we       = gnt_port ? we1    : we0;
        sel_wdata    = gnt_port ? wdata1 : wdata0;
        sel_in_range = ({1'b0, sel_addr} < DEPTH_X);
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        last_gnt_d  = last_gnt_q;
        port_d      = port_q;
        we_d        = we_q;
        ack0_d      = 1'b0;
        ack1_d      = 1'b0;
        rdata_d     = '0;
        err_d       = 1'b0;
        busy_d      = 1'b0;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        unique case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    last_gnt_d = gnt_port;
                    port_d     = gnt_port;
                    we_d       = sel_we;
                    busy_d     = 1'b1;
                    if (sel_in_range) begin
                        state_d     = ACCESS;
                        mem_addr_d  = sel_addr;
                        mem_wdata_d = sel_wdata;
                        mem_read_d  = ~sel_we;
                        mem_write_d = sel_we;
                    end else begin
                        // Rejected access skips the bank and completes with err.
                        state_d = DONE;
                        err_d   = 1'b1;
                        ack0_d  = ~gnt_port;
                        ack1_d  = gnt_port;
                    end
                end
            end
            ACCESS: begin
                state_d = DONE;
                busy_d  = 1'b1;
                rdata_d = we_q ? '0 : mem_rdata;
                ack0_d  = ~port_q;
                ack1_d  = port_q;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; async clear also aborts an in-flight write strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            last_gnt_q  <= 1'b1;
            port_q      <= 1'b0;
            we_q        <= 1'b0;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            last_gnt_q  <= last_gnt_d;
            port_q      <= port_d;
            we_q        <= we_d;
            ack0_q      <= ack0_d;
            ack1_q      <= ack1_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign ack0      = ack0_q;
    assign ack1      = ack1_q;
    assign rdata     = rdata_q;
    assign err       = err_q;
    assign busy      = busy_q;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a falling-edge-write bank model.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, we0, req1, we1;
    logic [15:0] addr0, wdata0, addr1, wdata1;
    logic        ack0, ack1, err, busy, mem_read, mem_write;
    logic [15:0] rdata, mem_addr, mem_wdata, mem_rdata;

    int errors = 0;
    int checks = 0;

    logic [15:0] bank [256];
    logic        loaded = 1'b0;
    logic [7:0]  bank_idx;

    dmem_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0      (req0),
        .addr0     (addr0),
        .we0       (we0),
        .wdata0    (wdata0),
        .ack0      (ack0),
        .req1      (req1),
        .addr1     (addr1),
        .we1       (we1),
        .wdata1    (wdata1),
        .ack1      (ack1),
        .rdata     (rdata),
        .err       (err),
        .busy      (busy),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    assign bank_idx  = 8'(mem_addr % 16'd256);
    assign mem_rdata = bank[bank_idx];

    // Bank: preload mem[i]=i on the first falling edge, then write on falling edges.
    always @(negedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 256; i++) bank[i] <= 16'(i);
            loaded <= 1'b1;
        end else if (mem_write) begin
            bank[bank_idx] <= mem_wdata;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
        req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
        tick();
        tick();
        check("rst_ack0", 32'(ack0), 0);
        check("rst_ack1", 32'(ack1), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_mem_read", 32'(mem_read), 0);
        check("rst_mem_write", 32'(mem_write), 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        check("rst_mem_wdata", 32'(mem_wdata), 0);
        check("rst_rdata", 32'(rdata), 0);
        check("rst_err", 32'(err), 0);
        rst_n = 1'b1;
        tick();

        // Port 0 read of address 19.
        req0 = 1'b1; addr0 = 16'd19; we0 = 1'b0;
        tick();
        check("rd19_mem_read", 32'(mem_read), 1);
        check("rd19_mem_write", 32'(mem_write), 0);
        check("rd19_mem_addr", 32'(mem_addr), 19);
        check("rd19_busy", 32'(busy), 1);
        check("rd19_early_ack0", 32'(ack0), 0);
        tick();
        check("rd19_ack0", 32'(ack0), 1);
        check("rd19_ack1", 32'(ack1), 0);
        check("rd19_rdata", 32'(rdata), 32'h13);
        check("rd19_err", 32'(err), 0);
        check("rd19_strobe_off", 32'(mem_read), 0);
        req0 = 1'b0;
        tick();
        check("rd19_idle_ack0", 32'(ack0), 0);
        check("rd19_idle_rdata", 32'(rdata), 0);
        check("rd19_idle_busy", 32'(busy), 0);

        // Port 1 write 0xBEEF to 20, then held req becomes a read of 20.
        req1 = 1'b1; addr1 = 16'd20; we1 = 1'b1; wdata1 = 16'hBEEF;
        tick();
        check("wr20_mem_write", 32'(mem_write), 1);
        check("wr20_mem_read", 32'(mem_read), 0);
        check("wr20_mem_addr", 32'(mem_addr), 20);
        check("wr20_mem_wdata", 32'(mem_wdata), 32'hBEEF);
        tick();
        check("wr20_write_one_cycle", 32'(mem_write), 0);
        check("wr20_ack1", 32'(ack1), 1);
        check("wr20_ack0", 32'(ack0), 0);
        check("wr20_rdata_zero", 32'(rdata), 0);
        we1 = 1'b0;
        tick();
        check("rd20_idle_busy", 32'(busy), 0);
        check("rd20_idle_write", 32'(mem_write), 0);
        tick();
        check("rd20_mem_read", 32'(mem_read), 1);
        check("rd20_mem_addr", 32'(mem_addr), 20);
        tick();
        check("rd20_ack1", 32'(ack1), 1);
        check("rd20_rdata", 32'(rdata), 32'hBEEF);
        req1 = 1'b0;
        tick();

        // Fresh reset, then both ports request continuously: 0,1,0,1,0,1.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        req0 = 1'b1; addr0 = 16'd1; we0 = 1'b0;
        req1 = 1'b1; addr1 = 16'd2; we1 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("rr_mem_addr", 32'(mem_addr), (i % 2 == 0) ? 32'd1 : 32'd2);
            tick();
            check("rr_ack0", 32'(ack0), (i % 2 == 0) ? 32'd1 : 32'd0);
            check("rr_ack1", 32'(ack1), (i % 2 == 1) ? 32'd1 : 32'd0);
            check("rr_rdata", 32'(rdata), (i % 2 == 0) ? 32'd1 : 32'd2);
            if (i == 5) begin
                req0 = 1'b0;
                req1 = 1'b0;
            end
            tick();
            check("rr_idle_busy", 32'(busy), 0);
        end

        // Out-of-range read: no strobe, immediate ack with err.
        req0 = 1'b1; addr0 = 16'd300; we0 = 1'b0;
        tick();
        check("oor_ack0", 32'(ack0), 1);
        check("oor_err", 32'(err), 1);
        check("oor_rdata", 32'(rdata), 0);
        check("oor_mem_read", 32'(mem_read), 0);
        check("oor_mem_write", 32'(mem_write), 0);
        check("oor_mem_addr_held", 32'(mem_addr), 2);
        check("oor_busy", 32'(busy), 1);
        req0 = 1'b0;
        tick();
        check("oor_idle_err", 32'(err), 0);
        check("oor_idle_ack0", 32'(ack0), 0);
        check("oor_idle_busy", 32'(busy), 0);

        // Reset during ACCESS before the falling edge aborts the write.
        req0 = 1'b1; addr0 = 16'd5; we0 = 1'b1; wdata0 = 16'h1234;
        tick();
        check("abort_mem_write_pre", 32'(mem_write), 1);
        #1 rst_n = 1'b0;
        #1;
        check("abort_mem_write_drop", 32'(mem_write), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_ack0", 32'(ack0), 0);
        req0 = 1'b0;
        @(negedge clk);
        #1;
        check("abort_bank5", 32'(bank[5]), 5);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("abort_no_ack0", 32'(ack0), 0);
            check("abort_idle_busy", 32'(busy), 0);
        end

        // Held req0 repeats; port 1 arriving mid-access is served in between.
        req0 = 1'b1; addr0 = 16'd7; we0 = 1'b0;
        tick();
        check("hold_acc1_addr", 32'(mem_addr), 7);
        req1 = 1'b1; addr1 = 16'd8; we1 = 1'b0;
        tick();
        check("hold_ack0_first", 32'(ack0), 1);
        check("hold_ack1_first", 32'(ack1), 0);
        check("hold_rdata_first", 32'(rdata), 7);
        tick();
        tick();
        check("hold_p1_addr", 32'(mem_addr), 8);
        tick();
        check("hold_p1_ack1", 32'(ack1), 1);
        check("hold_p1_ack0", 32'(ack0), 0);
        check("hold_p1_rdata", 32'(rdata), 8);
        req1 = 1'b0;
        tick();
        tick();
        check("hold_p0_again_addr", 32'(mem_addr), 7);
        check("hold_p0_again_read", 32'(mem_read), 1);
        tick();
        check("hold_p0_again_ack0", 32'(ack0), 1);
        check("hold_p0_again_rdata", 32'(rdata), 7);
        req0 = 1'b0;
        tick();
        check("final_busy", 32'(busy), 0);
        check("final_ack0", 32'(ack0), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
